// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding and baud/oversample constants.
package uart_pkg;

    localparam int unsigned DEFAULT_CLK_HZ = 12_000_000;
    localparam int unsigned DEFAULT_BAUD   = 9600;
    localparam int unsigned OVERSAMPLE     = 16;
    localparam int unsigned MID_TICK       = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    // Clocks per oversample tick, truncated.
    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Received-byte FIFO: power-of-two depth, extra pointer MSB distinguishes full from empty.
module uart_rx_fifo
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [7:0]  r_mem [DEPTH];
    logic        w_push_ok;
    logic        w_pop_ok;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds.
    assign w_pop_ok  = pop & ~empty;
    assign w_push_ok = push & (~full | w_pop_ok);

    assign dout = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr[AW-1:0]] <= din;
                r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver with 16x oversampling, mid-bit sampling and a small output FIFO.
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = DEFAULT_CLK_HZ,
    parameter int unsigned BAUD       = DEFAULT_BAUD,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned   DIV       = baud_div(CLK_HZ, BAUD);
    localparam int unsigned   DW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [3:0]    TICK_MID  = 4'(MID_TICK - 1);
    localparam logic [3:0]    TICK_LAST = 4'(OVERSAMPLE - 1);

    logic [1:0]    r_sync;
    logic [1:0]    r_settle;
    logic          r_rx_prev;
    logic          w_rx;
    logic          w_fall;

    rx_state_t     r_state;
    rx_state_t     w_state_nxt;

    logic [DW-1:0] r_div_cnt;
    logic [3:0]    r_tick_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_frame_err;
    logic          r_overrun;

    logic          w_tick;
    logic          w_enter_start;
    logic          w_sample;
    logic          w_shift_en;
    logic          w_push;
    logic          w_bad_stop;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx};
        end
    end

    assign w_rx = r_sync[1];

    // Edge history is held low until the synchronizer carries real line data, so a
    // line that is already low when reset releases never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle  <= '0;
            r_rx_prev <= 1'b0;
        end else begin
            if (r_settle != 2'd2) begin
                r_settle <= r_settle + 2'd1;
            end
            r_rx_prev <= (r_settle == 2'd2) & w_rx;
        end
    end

    assign w_fall = r_rx_prev & ~w_rx;
    assign w_tick = (r_state != ST_IDLE) && (r_div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_enter_start = 1'b0;
        w_sample      = 1'b0;
        w_shift_en    = 1'b0;
        w_push        = 1'b0;
        w_bad_stop    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    w_state_nxt   = ST_START;
                    w_enter_start = 1'b1;
                end
            end
            ST_START: begin
                if (w_tick && (r_tick_cnt == TICK_MID)) begin
                    w_sample    = 1'b1;
                    w_state_nxt = w_rx ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tick && (r_tick_cnt == TICK_LAST)) begin
                    w_sample   = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (w_tick && (r_tick_cnt == TICK_LAST)) begin
                    w_sample    = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_push      = w_rx;
                    w_bad_stop  = ~w_rx;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Tick counter restarts after each sample, so the next sample lands one full bit later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt  <= '0;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
        end else if (w_enter_start) begin
            r_div_cnt  <= '0;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (r_state != ST_IDLE) begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + DW'(1);
            if (w_tick) begin
                r_tick_cnt <= w_sample ? 4'd0 : r_tick_cnt + 4'd1;
            end
            if (w_shift_en) begin
                r_shift   <= {w_rx, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
        end
    end

    assign rx_valid = ~w_empty;
    assign w_pop    = rx_valid & rx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_bad_stop;
            r_overrun   <= w_push & w_full & ~w_pop;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .din   (r_shift),
        .pop   (w_pop),
        .dout  (rx_data),
        .full  (w_full),
        .empty (w_empty)
    );

    assign rx_busy   = (r_state != ST_IDLE);
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed bench for uart_rx_8n1 at 1248 clocks per bit.
module tb_uart_rx_8n1;

    localparam int unsigned BIT_CLKS = 1248;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       rx       = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    int unsigned n_checks  = 0;
    int unsigned n_errors  = 0;
    int unsigned fe_cnt    = 0;
    int unsigned ov_cnt    = 0;
    int unsigned vrise_cnt = 0;
    logic        valid_q   = 1'b0;
    logic [7:0]  got [$];

    uart_rx_8n1 #(
        .CLK_HZ     (12_000_000),
        .BAUD       (9600),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Observe on the falling edge; a byte is logged when it is accepted at the next rising edge.
    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cnt++;
        if (overrun === 1'b1) ov_cnt++;
        if (rx_valid === 1'b1 && valid_q !== 1'b1) vrise_cnt++;
        valid_q = rx_valid;
        if (rx_valid === 1'b1 && rx_ready === 1'b1) got.push_back(rx_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(BIT_CLKS);
        end
        rx = stop_bit;
        wait_clks(BIT_CLKS);
        rx = 1'b1;
    endtask

    initial begin
        logic [7:0]  msg [6];
        logic [7:0]  a5;
        int          nb;
        int unsigned fe0;
        int unsigned ov0;
        int unsigned vr0;
        int unsigned cyc;
        int unsigned hi;

        msg = '{8'h42, 8'h48, 8'h49, 8'h4E, 8'h49, 8'h0A};
        a5  = 8'hA5;

        // Reset
        #2 rst_n = 1'b0;
        wait_clks(5);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_data", 32'(rx_data), 32'h00);
        check("rst_busy", 32'(rx_busy), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        wait_clks(20);
        check("post_rst_busy", 32'(rx_busy), 32'd0);

        // Single byte 0x42, consumer always ready
        rx_ready = 1'b1;
        nb = got.size(); fe0 = fe_cnt; ov0 = ov_cnt; vr0 = vrise_cnt;
        send_frame(8'h42, 1'b1);
        wait_clks(50);
        check("b42_count", 32'(got.size() - nb), 32'd1);
        check("b42_data", 32'(got[nb]), 32'h42);
        check("b42_vrise", 32'(vrise_cnt - vr0), 32'd1);
        check("b42_ferr", 32'(fe_cnt - fe0), 32'd0);
        check("b42_ovr", 32'(ov_cnt - ov0), 32'd0);
        check("b42_valid_after", 32'(rx_valid), 32'd0);

        // 300-clock low glitch
        nb = got.size(); fe0 = fe_cnt; ov0 = ov_cnt; vr0 = vrise_cnt;
        rx = 1'b0;
        wait_clks(10);
        check("glitch_busy_high", 32'(rx_busy), 32'd1);
        wait_clks(290);
        rx = 1'b1;
        cyc = 300;
        while (rx_busy === 1'b1 && cyc < 700) begin
            wait_clks(1);
            cyc++;
        end
        check("glitch_busy_clear", 32'(rx_busy), 32'd0);
        wait_clks(20);
        check("glitch_count", 32'(got.size() - nb), 32'd0);
        check("glitch_vrise", 32'(vrise_cnt - vr0), 32'd0);
        check("glitch_ferr", 32'(fe_cnt - fe0), 32'd0);
        check("glitch_ovr", 32'(ov_cnt - ov0), 32'd0);

        // 0x55 with the stop bit held low
        nb = got.size(); fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(8'h55, 1'b0);
        wait_clks(50);
        check("ferr_pulse", 32'(fe_cnt - fe0), 32'd1);
        check("ferr_count", 32'(got.size() - nb), 32'd0);
        check("ferr_valid", 32'(rx_valid), 32'd0);
        check("ferr_ovr", 32'(ov_cnt - ov0), 32'd0);

        // "BHINI\n" back-to-back with the consumer stalled
        rx_ready = 1'b0;
        nb = got.size(); fe0 = fe_cnt; ov0 = ov_cnt;
        for (int i = 0; i < 6; i++) send_frame(msg[i], 1'b1);
        wait_clks(50);
        check("ovr_count", 32'(got.size() - nb), 32'd0);
        check("ovr_valid", 32'(rx_valid), 32'd1);
        check("ovr_head", 32'(rx_data), 32'h42);
        check("ovr_pulses", 32'(ov_cnt - ov0), 32'd2);
        check("ovr_ferr", 32'(fe_cnt - fe0), 32'd0);

        // FIFO still full; 0x0A arrives with rx_ready rising on the push cycle
        // (stop sample falls 11859 clocks after the start bit is driven).
        ov0 = ov_cnt;
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = msg[5][i];
            wait_clks(BIT_CLKS);
        end
        rx = 1'b1;
        wait_clks(626);
        rx_ready = 1'b1;
        wait_clks(BIT_CLKS - 626);
        wait_clks(50);
        check("full_pp_ovr", 32'(ov_cnt - ov0), 32'd0);
        check("full_pp_count", 32'(got.size() - nb), 32'd5);
        check("pop0", 32'(got[nb]), 32'h42);
        check("pop1", 32'(got[nb + 1]), 32'h48);
        check("pop2", 32'(got[nb + 2]), 32'h49);
        check("pop3", 32'(got[nb + 3]), 32'h4E);
        check("pop4_last", 32'(got[nb + 4]), 32'h0A);
        check("drained_valid", 32'(rx_valid), 32'd0);

        // Reset during bit 4 of 0xA5 (a low bit), released while the line is still low
        nb = got.size(); fe0 = fe_cnt; ov0 = ov_cnt;
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rx = a5[i];
            wait_clks(BIT_CLKS);
        end
        rx = a5[4];
        wait_clks(400);
        check("rst_mid_busy_before", 32'(rx_busy), 32'd1);
        rst_n = 1'b0;
        #2;
        check("rst_mid_busy_async", 32'(rx_busy), 32'd0);
        check("rst_mid_valid", 32'(rx_valid), 32'd0);
        wait_clks(5);
        rst_n = 1'b1;
        hi = 0;
        for (int i = 0; i < 800; i++) begin
            wait_clks(1);
            if (rx_busy !== 1'b0) hi++;
        end
        check("rst_low_line_idle", 32'(hi), 32'd0);
        rx = 1'b1;
        wait_clks(200);
        send_frame(8'h3C, 1'b1);
        wait_clks(50);
        check("b3c_count", 32'(got.size() - nb), 32'd1);
        check("b3c_data", 32'(got[nb]), 32'h3C);
        check("b3c_ferr", 32'(fe_cnt - fe0), 32'd0);
        check("b3c_ovr", 32'(ov_cnt - ov0), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_8n1.md
UART_RX_8N1 -- requirements
Module: uart_rx_8n1

Interface
REQ-001 Parameter CLK_HZ, default 12000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line bit rate.
REQ-003 Parameter FIFO_DEPTH, default 4, received-byte buffer depth; power of two, at least 2.
REQ-004 clk  input  1  system clock; one clock domain; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 rx_data  output  8  byte at FIFO head; valid only while rx_valid=1.
REQ-008 rx_valid  output  1  FIFO not empty.
REQ-009 rx_ready  input  1  consumer accepts rx_data on a cycle with rx_valid=1 and rx_ready=1.
REQ-010 rx_busy  output  1  high whenever the receive FSM is not in IDLE.
REQ-011 frame_err  output  1  one-cycle pulse when the stop-bit sample is 0.
REQ-012 overrun  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-013 rx shall pass a 2-flop synchronizer, reset to 1, before any use; this adds 2 cycles of input latency.
REQ-014 An oversample tick shall be generated every DIV = CLK_HZ/(BAUD*16) clocks, truncated (78 at defaults); the divider counter shall restart at 0 on entry to START.
REQ-015 FSM states: IDLE, START, DATA, STOP.
REQ-016 IDLE: a 1->0 transition on synchronized rx shall cause a move to START.
REQ-017 START: at tick 8 (mid-bit), rx=0 shall cause a move to DATA; rx=1 shall be treated as a glitch, with a return to IDLE and no output.
REQ-018 DATA: rx shall be sampled every 16 ticks after the mid-start point into a shift register, LSB first; after bit 7 the FSM shall move to STOP.
REQ-019 STOP: the stop bit shall be sampled 16 ticks after bit 7.
REQ-020 STOP, sample=1: the byte shall be pushed to the FIFO.
REQ-021 STOP, sample=0: frame_err shall pulse and the byte shall be discarded.
REQ-022 Either STOP outcome shall return the FSM to IDLE on the same cycle; a new start bit is accepted only after a subsequent 1->0 edge.
REQ-023 Push-to-rx_valid latency shall be 1 clock.
REQ-024 Pop shall occur on rx_valid & rx_ready; rx_data shall change only on a pop or on a push into an empty FIFO.
REQ-025 Push when full without a same-cycle pop shall drop the byte, pulse overrun, and leave the FIFO contents unchanged.
REQ-026 Push and pop in the same cycle when full shall both succeed, with no overrun.
REQ-027 Push and pop in the same cycle when empty cannot occur, because rx_valid=0.
REQ-028 FIFO pointers shall be log2(FIFO_DEPTH)+1 bits wide and wrap naturally; full = MSBs differ and the rest are equal; empty = all bits equal.
REQ-029 frame_err and overrun shall never both be high in the same cycle.

Reset
REQ-030 While rst_n=0, asynchronously: FSM=IDLE, FIFO empty, rx_valid=0, rx_data=0x00, rx_busy=0, frame_err=0, overrun=0, synchronizer=1, all counters=0.
REQ-031 Reset mid-frame shall discard the partial byte; after release the block shall wait for a fresh 1->0 edge, so a low line at release does not start a frame.
REQ-032 Reset deassertion may be asynchronous to clk; the integrator shall synchronize it upstream.

Structure
REQ-033 Shared header uart_pkg shall hold: the FSM state encodings, OVERSAMPLE=16, MID_TICK=8, DEFAULT_CLK_HZ, DEFAULT_BAUD; uart_tx_8n1 shall reuse the baud constants.
REQ-034 The FIFO shall be the sub-module uart_rx_fifo (parameter DEPTH, width 8, ports push/din/pop/dout/full/empty, same clk/rst_n); uart_rx_8n1 shall instantiate it once.

Verification
REQ-035 Bench shall drive a frame for 0x42 at 1248 clk/bit with rx_ready=1 -> rx_valid pulses once, rx_data=0x42, frame_err=0, overrun=0.
REQ-036 Bench shall drive a 300-clk low glitch on rx -> no rx_valid, rx_busy returns to 0 within 700 clks, no error pulse.
REQ-037 Bench shall drive 0x55 with the stop bit held low -> frame_err pulses once, FIFO stays empty.
REQ-038 Bench shall send "BHINI\n" back-to-back with rx_ready=0 -> bytes 'B','H','I','N' buffered, overrun pulses twice; raising rx_ready then pops B,H,I,N in order.
REQ-039 Bench shall fill the FIFO, then hold rx_ready=1 while a fifth byte 0x0A completes -> no overrun, and 0x0A is popped last.
REQ-040 Bench shall assert rst_n=0 during bit 4 of 0xA5, release it, then send 0x3C -> only 0x3C is received, with no error pulse.
